mm_seq_ctrl: RTL and testbench
==============================

Name: mm_seq_ctrl

Overview:
- Sequencer for the 3x3 matrix-multiply datapath (memory bank + MAC array).
- On a go request it:
  - clears the bank and MACs;
  - streams 9 weight nibbles, then 9 activation nibbles, into the bank using a valid/ready handshake;
  - waits for the bank's start flag;
  - steps unload1..unload3 with the MAC load enable, drains, then reports done or a timeout error.
- Sits between the host/testbench and the datapath's control pins. Data itself bypasses this block.

Parameters:
- ELEMS, 9, operand elements per matrix (3x3).
- UNLOAD_CYC, 3, cycles each unloadN is held high.
- DRAIN_CYC, 3, extra ld cycles after unload3 to flush the MAC pipeline.
- START_TO, 16, maximum cycles to wait for start before error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- go  input  1  request a full multiply; sampled only in IDLE.
- in_valid  input  1  host presents a nibble on the datapath data_in this cycle.
- in_ready  output  1  controller will accept the nibble (LOADW/LOADX only).
- start  input  1  memory bank reports both operand sets resident.
- ldw  output  1  weight write strobe to the bank.
- ldx  output  1  activation write strobe to the bank.
- clear_mem  output  1  bank clear.
- clear_mac  output  1  MAC accumulator clear.
- unload1, unload2, unload3  output  1 each  bank read-out phase selects; one-hot or all-zero.
- ld  output  1  MAC accumulate enable.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky start-timeout flag; cleared by the next accepted go or by reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = IDLE, all counters = 0.
  - All outputs 0: in_ready, ldw, ldx, clear_mem, clear_mac, unloadN, ld, busy, done, err.
- Reset mid-operation aborts immediately. No partial done.
- Output timing:
  - All outputs are Moore decodes of registered state, except ldw = (state==LOADW) & in_valid and ldx = (state==LOADX) & in_valid.
  - in_ready is Moore.
- Element counter: 4 bits, counts accepted transfers (in_valid & in_ready). Phase counter: 5 bits, shared by WAIT/UNLOAD/DRAIN.
- States and transitions:
  - IDLE: go=1 -> CLR; clear err. go while busy is ignored (not queued).
  - CLR: exactly 1 cycle with clear_mem=clear_mac=1 -> LOADW. Element counter = 0.
  - LOADW: in_ready=1. Each accepted transfer increments the counter. The 9th accept (counter==ELEMS-1 and accept) -> LOADX, counter = 0. in_valid low stalls indefinitely with no timeout.
  - LOADX: same as LOADW, using ldx. 9th accept -> WAIT_ST, phase counter = 0.
  - WAIT_ST: start=1 -> U1, phase = 0. Otherwise phase increments. Phase==START_TO-1 with start=0 -> IDLE with err=1.
    - If start is already high on the first WAIT_ST cycle, go to U1 next cycle.
  - U1 / U2 / U3: unloadN=1 and ld=1 for exactly UNLOAD_CYC cycles each, back-to-back with no gap. U3 -> DRAIN.
  - DRAIN: ld=1, unloadN=0, for DRAIN_CYC cycles -> DONE.
  - DONE: done=1, busy=1 for 1 cycle -> IDLE.
- Latency: go to done = 1 + 1 + 9 + 9 + W + 3*UNLOAD_CYC + DRAIN_CYC + 1 cycles, where W = WAIT_ST cycles (>=1), all in-stream valids high.
  - With defaults and start already high: 1(IDLE sample) + 1 + 18 + 1 + 9 + 3 + 1 = 34 cycles from the go-sample edge to the done-high cycle.
- Invariants:
  - ldw and ldx are never high together.
  - clear_* is never high with ld.
  - At most one unloadN is high.
- start dropping during U1..DRAIN is ignored.
- start high outside WAIT_ST is ignored.

Test Plan:
- Nominal run: reset, go=1 for 1 cycle, in_valid held 1, start tied 1 -> exactly 9 ldw pulses then 9 ldx pulses.
  - unload1/2/3 each high 3 consecutive cycles, then ld high 3 more cycles.
  - done pulses once 34 cycles after the go edge; busy low the cycle after.
- Stalled stream: in_valid toggles 1,0,0,1,... -> ldw/ldx count is still exactly 9 each, and each strobe coincides with in_valid=1. LOADW->LOADX occurs only on the 9th accept.
- Start timeout: start tied 0 -> after 16 WAIT_ST cycles the controller returns to IDLE, err=1, done never asserted, no unloadN asserted. A following go clears err.
- Late start: start rises 5 cycles into WAIT_ST -> U1 begins the next cycle; total latency is 38 cycles.
- Reset mid-op: deassert rst_n during U2 -> all outputs 0 asynchronously. After release, state is IDLE and busy=0; go starts a clean CLR.
- go during busy: pulse go while in LOADX -> no effect; exactly one done for the original request.

Source files
------------

// File: rtl/mm_seq_ctrl_if.sv
// Control-plane bundle between the host, the matrix-multiply sequencer and
// the datapath control pins. The master side is the host (go / in_valid /
// start); the slave side is the sequencer, which drives every strobe.
interface mm_seq_ctrl_if;
  logic go;
  logic in_valid;
  logic in_ready;
  logic start;
  logic ldw;
  logic ldx;
  logic clear_mem;
  logic clear_mac;
  logic unload1;
  logic unload2;
  logic unload3;
  logic ld;
  logic busy;
  logic done;
  logic err;

  modport master (
    output go, in_valid, start,
    input  in_ready, ldw, ldx, clear_mem, clear_mac,
           unload1, unload2, unload3, ld, busy, done, err
  );

  modport slave (
    input  go, in_valid, start,
    output in_ready, ldw, ldx, clear_mem, clear_mac,
           unload1, unload2, unload3, ld, busy, done, err
  );
endinterface

// File: rtl/mm_seq_ctrl.sv
// Sequencer for the 3x3 matrix-multiply datapath. One go request clears the
// bank and MACs, streams 9 weight and 9 activation nibbles into the bank,
// waits for the bank's start flag, steps the three unload phases with the MAC
// accumulate enable, drains the MAC pipeline and reports done, or flags a
// sticky error if start never arrives.
module mm_seq_ctrl #(
  parameter int ELEMS      = 9,
  parameter int UNLOAD_CYC = 3,
  parameter int DRAIN_CYC  = 3,
  parameter int START_TO   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mm_seq_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_LOADW,
    S_LOADX,
    S_WAIT,
    S_U1,
    S_U2,
    S_U3,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] ELEM_LAST   = 4'(ELEMS - 1);
  localparam logic [4:0] UNLOAD_LAST = 5'(UNLOAD_CYC - 1);
  localparam logic [4:0] DRAIN_LAST  = 5'(DRAIN_CYC - 1);
  localparam logic [4:0] TO_LAST     = 5'(START_TO - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_elem;
  logic [4:0] r_phase;
  logic       r_err;

  logic w_loading;
  logic w_accept;
  logic w_elem_last;
  logic w_phase_st;
  logic w_timeout;
  logic w_leave;

  assign w_loading   = (r_state == S_LOADW) || (r_state == S_LOADX);
  assign w_accept    = w_loading && bus.in_valid;
  assign w_elem_last = (r_elem == ELEM_LAST);
  assign w_phase_st  = (r_state == S_WAIT) || (r_state == S_U1) || (r_state == S_U2) ||
                       (r_state == S_U3)   || (r_state == S_DRAIN);
  assign w_timeout   = (r_state == S_WAIT) && !bus.start && (r_phase == TO_LAST);
  assign w_leave     = (w_state_next != r_state);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so that every path assigns w_state_next and no
    // latch is inferred for the hold case.
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.go) w_state_next = S_CLR;
      S_CLR:   w_state_next = S_LOADW;
      S_LOADW: if (w_accept && w_elem_last) w_state_next = S_LOADX;
      S_LOADX: if (w_accept && w_elem_last) w_state_next = S_WAIT;
      S_WAIT: begin
        if (bus.start)     w_state_next = S_U1;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_U1:    if (r_phase == UNLOAD_LAST) w_state_next = S_U2;
      S_U2:    if (r_phase == UNLOAD_LAST) w_state_next = S_U3;
      S_U3:    if (r_phase == UNLOAD_LAST) w_state_next = S_DRAIN;
      S_DRAIN: if (r_phase == DRAIN_LAST)  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Element / phase counters restart on every state change; err is sticky
  // until the next accepted go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elem  <= '0;
      r_phase <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_leave)       r_elem <= '0;
      else if (w_accept) r_elem <= r_elem + 4'd1;

      if (w_leave)         r_phase <= '0;
      else if (w_phase_st) r_phase <= r_phase + 5'd1;

      if ((r_state == S_IDLE) && bus.go) r_err <= 1'b0;
      else if (w_timeout)                r_err <= 1'b1;
    end
  end

  // Output decode: Moore on state, except the write strobes gated by in_valid.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.ldw       = 1'b0;
    bus.ldx       = 1'b0;
    bus.clear_mem = 1'b0;
    bus.clear_mac = 1'b0;
    bus.unload1   = 1'b0;
    bus.unload2   = 1'b0;
    bus.unload3   = 1'b0;
    bus.ld        = 1'b0;
    bus.busy      = (r_state != S_IDLE);
    bus.done      = 1'b0;
    bus.err       = r_err;
    unique case (r_state)
      S_CLR: begin
        bus.clear_mem = 1'b1;
        bus.clear_mac = 1'b1;
      end
      S_LOADW: begin
        bus.in_ready = 1'b1;
        bus.ldw      = bus.in_valid;
      end
      S_LOADX: begin
        bus.in_ready = 1'b1;
        bus.ldx      = bus.in_valid;
      end
      S_U1: begin
        bus.unload1 = 1'b1;
        bus.ld      = 1'b1;
      end
      S_U2: begin
        bus.unload2 = 1'b1;
        bus.ld      = 1'b1;
      end
      S_U3: begin
        bus.unload3 = 1'b1;
        bus.ld      = 1'b1;
      end
      S_DRAIN: bus.ld   = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Self-checking bench for mm_seq_ctrl. A transaction-level model (accepted
// element count, wait-cycle count, post-start elapsed count) predicts every
// output each cycle; directed runs pin latency and strobe counts with
// hand-computed numbers, then randomized runs exercise stalls and start timing.
module tb_mm_seq_ctrl;
  localparam int ELEMS      = 9;
  localparam int UNLOAD_CYC = 3;
  localparam int DRAIN_CYC  = 3;
  localparam int START_TO   = 16;
  localparam int POST_LEN   = 3 * UNLOAD_CYC + DRAIN_CYC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mm_seq_ctrl_if bus ();

  mm_seq_ctrl #(
    .ELEMS(ELEMS), .UNLOAD_CYC(UNLOAD_CYC), .DRAIN_CYC(DRAIN_CYC), .START_TO(START_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: busy/clearing flags, accepted transfers, wait cycles, post-start time.
  bit m_busy, m_clr, m_started, m_err;
  int m_acc, m_wait, m_t;

  // Observation counters, written only by the compare loop.
  int  cyc_total, n_ldw, n_ldx, n_done, n_un, last_done;
  bit  prev_done, busy_after_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] dut_out();
    return {bus.in_ready, bus.ldw, bus.ldx, bus.clear_mem, bus.clear_mac,
            bus.unload1, bus.unload2, bus.unload3, bus.ld, bus.busy, bus.done, bus.err};
  endfunction

  function automatic logic [11:0] model_out(input logic iv);
    logic loading, post, clr;
    logic [2:0] un;
    clr     = m_busy && m_clr;
    loading = m_busy && !m_clr && (m_acc < 2 * ELEMS);
    post    = m_busy && !m_clr && (m_acc >= 2 * ELEMS) && m_started;
    un      = 3'b000;
    if (post && m_t < 3 * UNLOAD_CYC) un = 3'b100 >> (m_t / UNLOAD_CYC);
    return {loading, loading && (m_acc < ELEMS) && iv, loading && (m_acc >= ELEMS) && iv,
            clr, clr, un, post && (m_t < POST_LEN), m_busy, post && (m_t == POST_LEN), m_err};
  endfunction

  // Reference model advance, one step per clock from the spec's rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_clr <= 0; m_started <= 0; m_err <= 0;
      m_acc <= 0; m_wait <= 0; m_t <= 0;
    end else if (!m_busy) begin
      if (bus.go) begin
        m_busy <= 1; m_clr <= 1; m_err <= 0; m_started <= 0;
        m_acc <= 0; m_wait <= 0; m_t <= 0;
      end
    end else if (m_clr) begin
      m_clr <= 0;
    end else if (m_acc < 2 * ELEMS) begin
      if (bus.in_valid) m_acc <= m_acc + 1;
    end else if (!m_started) begin
      if (bus.start) begin
        m_started <= 1; m_t <= 0;
      end else if (m_wait == START_TO - 1) begin
        m_busy <= 0; m_err <= 1;
      end else begin
        m_wait <= m_wait + 1;
      end
    end else if (m_t == POST_LEN) begin
      m_busy <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cyc_total++;
        check("outputs", 32'(dut_out()), 32'(model_out(bus.in_valid)));
        if (bus.ldw) n_ldw++;
        if (bus.ldx) n_ldx++;
        if (bus.unload1 || bus.unload2 || bus.unload3) n_un++;
        if (prev_done) busy_after_done = bus.busy;
        prev_done = bus.done;
        if (bus.done) begin
          n_done++;
          last_done = cyc_total;
        end
      end
    end
  endtask

  function automatic logic pick_valid(input int vmode, input int k);
    case (vmode)
      0:       return 1'b1;
      1:       return (k % 3 == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic pick_start(input int smode, input int start_at);
    case (smode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (m_acc >= 2 * ELEMS) && !m_started && (m_wait >= start_at);
      default: return ($urandom_range(0, 3) == 0);
    endcase
  endfunction

  // One go request driven to completion; returns latency and strobe counts.
  task automatic do_run(input int vmode, input int smode, input int start_at, input bit go_mid,
                        output int lat, output int dw, output int dx, output int dd, output int du);
    int k, go_cyc, b_w, b_x, b_d, b_u;
    bit sent;
    b_w = n_ldw; b_x = n_ldx; b_d = n_done; b_u = n_un;
    @(posedge clk); #1;
    bus.go       = 1'b1;
    go_cyc       = cyc_total + 1;
    bus.in_valid = pick_valid(vmode, 0);
    bus.start    = pick_start(smode, start_at);
    k    = 0;
    sent = 0;
    do begin
      @(posedge clk); #1;
      k++;
      bus.go = 1'b0;
      if (go_mid && !sent && m_busy && !m_clr && m_acc >= ELEMS && m_acc < 2 * ELEMS) begin
        bus.go = 1'b1;
        sent   = 1;
      end
      bus.in_valid = pick_valid(vmode, k);
      bus.start    = pick_start(smode, start_at);
    end while (m_busy && k < 400);
    if (m_busy) check("run_cycle_budget", 32'(k), 32'(0));
    @(negedge clk); #1;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    lat = last_done - go_cyc + 1;
    dw  = n_ldw - b_w;
    dx  = n_ldx - b_x;
    dd  = n_done - b_d;
    du  = n_un - b_u;
  endtask

  initial begin
    int lat, dw, dx, dd, du, k;
    bus.go = 1'b0; bus.in_valid = 1'b0; bus.start = 1'b0;
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1 check("reset_outputs", 32'(dut_out()), 32'(0));
    @(negedge clk); #1 rst_n = 1'b1;

    // Nominal: 9+9 strobes, 9 unload cycles, done 34 cycles from go sample.
    do_run(0, 0, 0, 0, lat, dw, dx, dd, du);
    check("nom_ldw", 32'(dw), 32'(9));
    check("nom_ldx", 32'(dx), 32'(9));
    check("nom_unload_cycles", 32'(du), 32'(9));
    check("nom_done_count", 32'(dd), 32'(1));
    check("nom_latency", 32'(lat), 32'(34));
    check("nom_busy_after_done", 32'(busy_after_done), 32'(0));

    // Stalled stream 1,0,0,1,...
    do_run(1, 0, 0, 0, lat, dw, dx, dd, du);
    check("stall_ldw", 32'(dw), 32'(9));
    check("stall_ldx", 32'(dx), 32'(9));
    check("stall_done_count", 32'(dd), 32'(1));

    // Start never arrives.
    do_run(0, 1, 0, 0, lat, dw, dx, dd, du);
    check("timeout_err", 32'(bus.err), 32'(1));
    check("timeout_done_count", 32'(dd), 32'(0));
    check("timeout_unload_cycles", 32'(du), 32'(0));

    // Next go clears err.
    do_run(0, 0, 0, 0, lat, dw, dx, dd, du);
    check("err_cleared", 32'(bus.err), 32'(0));
    check("after_err_latency", 32'(lat), 32'(34));

    // Start seen on the 5th WAIT_ST cycle.
    do_run(0, 2, 4, 0, lat, dw, dx, dd, du);
    check("late_start_latency", 32'(lat), 32'(38));

    // go pulsed during LOADX is ignored.
    do_run(0, 0, 0, 1, lat, dw, dx, dd, du);
    check("go_busy_done_count", 32'(dd), 32'(1));
    check("go_busy_latency", 32'(lat), 32'(34));

    // Reset during U2.
    @(posedge clk); #1;
    bus.go = 1'b1; bus.in_valid = 1'b1; bus.start = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      bus.go = 1'b0;
      k++;
    end while (!(m_started && m_t >= UNLOAD_CYC) && k < 200);
    check("reached_u2", 32'(dut_out()) & 32'h0E0, 32'h020);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'(dut_out()), 32'(0));
    bus.in_valid = 1'b0; bus.start = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1 check("post_reset_busy", 32'(bus.busy), 32'(0));
    do_run(0, 0, 0, 0, lat, dw, dx, dd, du);
    check("post_reset_latency", 32'(lat), 32'(34));
    check("post_reset_ldw", 32'(dw), 32'(9));

    // Randomized stalls, start timing and stray go pulses.
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_run(2, 3, 0, 1'($urandom_range(0, 1)), lat, dw, dx, dd, du);
      check("rand_ldw", 32'(dw), 32'(9));
      check("rand_ldx", 32'(dx), 32'(9));
      check("rand_done_count", 32'(dd), m_err ? 32'(0) : 32'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
